buffer_sched: RTL and testbench

Sequencing controller for the multi-stream circular sample buffer in the resampler input path. It owns the write/read pointers, occupancy, input/output req/ack handshakes and RAM enables, so the buffer datapath holds only storage and data registers. It also tracks the polyphase phase index, advancing it on each read-pointer round-trip, and emits the per-round shift decision consumed by the shift RAM banks.

---
 rtl/buffer_sched.sv | 114 +++++++++++
 tb/tb_buffer_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_sched.sv
// Sequencing controller for the multi-stream circular sample buffer: owns the
// pointers, occupancy, req/ack handshakes, RAM strobes and polyphase phase/shift.
module buffer_sched #(
  parameter int NR_STREAMS     = 16,
  parameter int NR_STREAMS_LOG = 4,
  parameter int L              = 3,
  parameter int L_LOG          = 2,
  parameter logic [L-1:0] SHIFT_PATTERN = 3'b101
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      req_in,
  input  logic                      ack_in,
  output logic                      req_out,
  input  logic                      ack_out,
  output logic                      wr_en,
  output logic [NR_STREAMS_LOG-1:0] wr_addr,
  output logic                      rd_en,
  output logic [NR_STREAMS_LOG-1:0] rd_addr,
  output logic                      shift,
  output logic [L_LOG-1:0]          phase,
  output logic [NR_STREAMS_LOG:0]   count,
  output logic                      full,
  output logic                      empty
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [NR_STREAMS_LOG:0]   FULL_COUNT = (NR_STREAMS_LOG+1)'(NR_STREAMS);
  localparam logic [NR_STREAMS_LOG-1:0] LAST_PTR   = NR_STREAMS_LOG'(NR_STREAMS-1);
  localparam logic [L_LOG-1:0]          LAST_PHASE = L_LOG'(L-1);

  state_t                    state;
  logic [NR_STREAMS_LOG-1:0] wr_ptr;
  logic [NR_STREAMS_LOG-1:0] rd_ptr;
  logic                      accept;
  logic                      fetch;
  logic [L_LOG-1:0]          next_phase;

  // Occupancy is tracked explicitly so all NR_STREAMS slots are usable.
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign req_in     = enable && !full;
  assign accept     = req_in && ack_in;
  assign wr_en      = accept;
  assign wr_addr    = wr_ptr;
  assign rd_addr    = rd_ptr;
  assign fetch      = (state == FETCH);
  assign next_phase = (phase == LAST_PHASE) ? '0 : phase + L_LOG'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + NR_STREAMS_LOG'(1);
      if (accept && !fetch)
        count <= count + (NR_STREAMS_LOG+1)'(1);
      else if (!accept && fetch)
        count <= count - (NR_STREAMS_LOG+1)'(1);
    end
  end

  // A started FETCH always completes into HOLD, and HOLD waits for ack_out
  // even when frozen, so an issued read is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_en   <= 1'b0;
      req_out <= 1'b0;
      rd_ptr  <= '0;
      phase   <= '0;
      shift   <= SHIFT_PATTERN[0];
    end else begin
      case (state)
        IDLE: begin
          if (enable && !empty) begin
            state <= FETCH;
            rd_en <= 1'b1;
          end
        end
        FETCH: begin
          state   <= HOLD;
          rd_en   <= 1'b0;
          req_out <= 1'b1;
          rd_ptr  <= rd_ptr + NR_STREAMS_LOG'(1);
          if (rd_ptr == LAST_PTR) begin
            phase <= next_phase;
            shift <= SHIFT_PATTERN[next_phase];
          end
        end
        HOLD: begin
          if (ack_out) begin
            req_out <= 1'b0;
            if (enable && count != '0) begin
              state <= FETCH;
              rd_en <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rd_en   <= 1'b0;
          req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_sched.sv
// Scoreboard bench for buffer_sched: accepted writes queue the expected read
// (address, phase, shift); a monitor checks every RAM read against the queue.
module tb_buffer_sched;

  typedef struct {
    logic [3:0] addr;
    logic [1:0] phase;
    logic       shift;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       req_in;
  logic       ack_in;
  logic       req_out;
  logic       ack_out;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       shift;
  logic [1:0] phase;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int         checks = 0;
  int         errors = 0;
  int         wrIdx  = 0;
  exp_t       expQ[$];
  exp_t       monE;
  logic [2:0] pattern = 3'b101;

  buffer_sched #(
    .NR_STREAMS(16), .NR_STREAMS_LOG(4), .L(3), .L_LOG(2), .SHIFT_PATTERN(3'b101)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .shift(shift), .phase(phase),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ai, input logic ao);
    enable  = en;
    ack_in  = ai;
    ack_out = ao;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Expected read for the idx-th sample since reset: FIFO order, one phase
  // step per 16 reads.
  task automatic pushExp();
    exp_t e;
    int   ph;
    ph      = (wrIdx / 16) % 3;
    e.addr  = 4'(wrIdx % 16);
    e.phase = 2'(ph);
    e.shift = pattern[ph];
    expQ.push_back(e);
    wrIdx++;
  endtask

  task automatic sendSample();
    int n = 0;
    @(negedge clk);
    while (!req_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("send_req_in", req_in, 1);
    nextCycle();
    ack_in = 1'b1;
    checkOutput("send_wr_addr_pre", 0, 0 * wrIdx);
    pushExp();
    @(negedge clk);
    checkOutput("send_wr_en", wr_en, 1);
    checkOutput("send_wr_addr", wr_addr, (wrIdx - 1) % 16);
    nextCycle();
    ack_in = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while (!(count == 0 && !req_out) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_count", count, 0);
    checkOutput("drain_req_out", req_out, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && rd_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_read: rd_addr=%0d, expected no read at %0t", rd_addr, $time);
      end else begin
        monE = expQ.pop_front();
        checkOutput("read_addr", rd_addr, monE.addr);
        checkOutput("read_phase", phase, monE.phase);
        checkOutput("read_shift", shift, monE.shift);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0);

    // Reset state
    @(negedge clk);
    checkOutput("rst_req_in", req_in, 0);
    checkOutput("rst_req_out", req_out, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_shift", shift, 1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("release_req_in", req_in, 1);

    // Fill: one read is fetched and parked in HOLD, so 17 accepts fill the buffer
    $display("[TB] fill test");
    for (int i = 0; i < 18; i++) begin
      nextCycle();
      applyStimulus(1, 1, 0);
      if (i < 17) pushExp();
      @(negedge clk);
      if (i < 17) begin
        checkOutput("fill_wr_en", wr_en, 1);
        checkOutput("fill_wr_addr", wr_addr, i % 16);
      end else begin
        checkOutput("blocked_wr_en", wr_en, 0);
        checkOutput("blocked_req_in", req_in, 0);
      end
    end
    nextCycle();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("full_count", count, 16);
    checkOutput("full_flag", full, 1);
    checkOutput("full_req_in", req_in, 0);

    // Drain: full drops the cycle after the FETCH at count 16
    $display("[TB] drain test");
    nextCycle();
    applyStimulus(1, 0, 1);
    @(negedge clk);
    checkOutput("drain_full_hold", full, 1);
    @(negedge clk);
    checkOutput("drain_fetch_rd_en", rd_en, 1);
    checkOutput("drain_fetch_count", count, 16);
    @(negedge clk);
    checkOutput("drain_full_drop", full, 0);
    checkOutput("drain_req_in", req_in, 1);
    checkOutput("drain_count15", count, 15);
    waitDrain();
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_reads_seen", expQ.size(), 0);

    // Single sample latency: req_out exactly 3 cycles after accept
    $display("[TB] latency test");
    nextCycle();
    applyStimulus(1, 1, 1);
    pushExp();
    @(negedge clk);
    checkOutput("single_wr_addr", wr_addr, 1);
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      applyStimulus(1, 0, 1);
      @(negedge clk);
      checkOutput("single_req_out", req_out, (k == 3) ? 1 : 0);
      checkOutput("single_rd_en", rd_en, (k == 2) ? 1 : 0);
    end
    checkOutput("single_count", count, 0);

    // Simultaneous accept and FETCH at count 5
    $display("[TB] simultaneous test");
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(1, 1, 0);
      pushExp();
      @(negedge clk);
      checkOutput("sim_wr_addr", wr_addr, 2 + i);
    end
    nextCycle();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("sim_count_pre", count, 5);
    checkOutput("sim_hold", req_out, 1);
    nextCycle();
    applyStimulus(1, 0, 1);
    nextCycle();
    applyStimulus(1, 1, 0);
    pushExp();
    @(negedge clk);
    checkOutput("sim_rd_en", rd_en, 1);
    checkOutput("sim_wr_en", wr_en, 1);
    checkOutput("sim_wr_addr8", wr_addr, 8);
    nextCycle();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("sim_count_post", count, 5);
    checkOutput("sim_rd_addr_next", rd_addr, 4);

    // Freeze in HOLD: req_out held until ack_out, then no FETCH until enabled
    $display("[TB] freeze test");
    nextCycle();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("frz_req_in", req_in, 0);
    checkOutput("frz_req_out1", req_out, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("frz_req_out2", req_out, 1);
    nextCycle();
    applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("frz_req_out3", req_out, 1);
    nextCycle();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("frz_idle_req_out", req_out, 0);
    checkOutput("frz_idle_rd_en", rd_en, 0);
    checkOutput("frz_idle_count", count, 5);
    nextCycle();
    @(negedge clk);
    checkOutput("frz_no_fetch", rd_en, 0);
    nextCycle();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("reen_same_cycle", rd_en, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("reen_fetch", rd_en, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("reen_count", count, 4);
    checkOutput("reen_req_out", req_out, 1);

    // Reset in HOLD with count 7
    $display("[TB] reset test");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1, 1, 0);
      pushExp();
      @(negedge clk);
      checkOutput("pre_rst_wr_addr", wr_addr, 9 + i);
    end
    nextCycle();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    checkOutput("pre_rst_count", count, 7);
    checkOutput("pre_rst_req_out", req_out, 1);
    checkOutput("pre_rst_phase", phase, 1);
    checkOutput("pre_rst_shift", shift, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_req_out", req_out, 0);
    checkOutput("arst_count", count, 0);
    checkOutput("arst_empty", empty, 1);
    checkOutput("arst_phase", phase, 0);
    checkOutput("arst_shift", shift, 1);
    checkOutput("arst_wr_addr", wr_addr, 0);
    checkOutput("arst_rd_addr", rd_addr, 0);
    expQ.delete();
    wrIdx = 0;
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 0, 1);
    @(negedge clk);
    checkOutput("post_rst_req_in", req_in, 1);
    checkOutput("post_rst_rd_en", rd_en, 0);

    // 48 samples: phase 0->1->2->0, shift 1->0->1->1
    $display("[TB] phase test");
    for (int i = 0; i < 48; i++) sendSample();
    waitDrain();
    checkOutput("phase_reads_seen", expQ.size(), 0);
    checkOutput("phase_wrapped", phase, 0);
    checkOutput("shift_wrapped", shift, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
